// File: rtl/dff_bank_rr_arbiter_if.sv
// Bus between the requesting datapath blocks (master) and the shared-register
// arbiter (slave). clock and reset stay outside as plain ports.
interface dff_bank_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
);
  // Protocol: req is a level held for as long as a requester wants the register.
  // gnt is one-hot and registered; a requester owns the register, and may write it
  // with wen, while its gnt bit is high. Dropping req releases it at the next edge.
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wen;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  sclr;
  logic [NREQ-1:0]       gnt;
  logic [IDXW-1:0]       owner;
  logic [WIDTH-1:0]      q;
  logic                  wen_err;
  logic                  dbg_state;

  modport master (
    output req, wen, wdata, sclr,
    input  gnt, owner, q, wen_err, dbg_state
  );

  modport slave (
    input  req, wen, wdata, sclr,
    output gnt, owner, q, wen_err, dbg_state
  );
endinterface

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register, with a
// per-grant hold cap, non-owner write rejection and a synchronous clear.
module dff_bank_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4,
  parameter int IDXW     = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  clear,
  dff_bank_rr_arbiter_if.slave  bus
);

  localparam int CNTW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]       r_state;
  logic [IDXW-1:0]  r_owner;
  logic [IDXW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_q;
  logic             r_wen_err;

  logic             w_found;
  logic [IDXW-1:0]  w_winner;
  logic [IDXW-1:0]  w_winner_ptr;
  logic [NREQ-1:0]  w_winner_oh;
  logic [IDXW-1:0]  w_scan_idx;
  logic             w_release;
  logic             w_own_wr;
  logic             w_bad_wen;
  logic [WIDTH-1:0] w_wdata;

  // r_ptr always holds (last owner + 1) mod NREQ, so while a grant is active the
  // current owner ranks last in the search and is re-granted only if alone.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan_idx = IDXW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  assign w_winner_ptr = IDXW'((int'(w_winner) + 1) % NREQ);
  assign w_winner_oh  = NREQ'(1) << w_winner;
  assign w_release    = !bus.req[r_owner] || (r_cnt == CNT_LAST);

  assign w_own_wr  = (r_state == S_OWN) && bus.wen[r_owner];
  assign w_wdata   = bus.wdata[r_owner*WIDTH +: WIDTH];
  // r_gnt is zero when idle, so any wen at all is an error then.
  assign w_bad_wen = |(bus.wen & ~r_gnt);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWN;
            r_owner <= w_winner;
            r_gnt   <= w_winner_oh;
            r_cnt   <= '0;
            r_ptr   <= w_winner_ptr;
          end
        end
        S_OWN: begin
          if (!w_release) begin
            r_cnt <= r_cnt + CNTW'(1);
          end else if (w_found) begin
            r_owner <= w_winner;
            r_gnt   <= w_winner_oh;
            r_cnt   <= '0;
            r_ptr   <= w_winner_ptr;
          end else begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // sclr has priority over an owner write in the same cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_q       <= '0;
      r_wen_err <= 1'b0;
    end else begin
      r_wen_err <= w_bad_wen;
      if (bus.sclr) begin
        r_q <= '0;
      end else if (w_own_wr) begin
        r_q <= w_wdata;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.owner     = r_owner;
  assign bus.q         = r_q;
  assign bus.wen_err   = r_wen_err;
  assign bus.dbg_state = r_state;

  a_gnt_onehot0: assert property (@(posedge clock) disable iff (clear) $onehot0(r_gnt));
  a_gnt_matches_state: assert property (@(posedge clock) disable iff (clear)
    ((r_state == S_OWN) == (r_gnt != '0)));

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Directed bench for dff_bank_rr_arbiter: driver pushes hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_dff_bank_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;
  localparam int W     = 31;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_bank_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  dff_bank_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(4), .IDXW(IDXW)) dut (
    .clock (clk),
    .clear (rst),
    .bus   (bus)
  );

  logic [15:0] cyc_cnt = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 16'd1;

  // scoreboard: {cyc[30:15], gnt[14:11], owner[10:9], q[8:1], err[0]}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h (cycle %0d)", nm, fld, act, expv, cyc_cnt);
    end
  endtask

  task automatic push_exp(input int off, input logic [3:0] g, input logic [1:0] o,
                          input logic [7:0] qv, input logic e, input string nm);
    exp_q.push_back({cyc_cnt + 16'(off), g, o, qv, e});
    name_q.push_back(nm);
  endtask

  // driver: apply inputs just after an edge; result is visible after the next edge
  task automatic cycle(input logic [3:0] rq, input logic [3:0] we, input logic [31:0] wd,
                       input logic sc, input logic [3:0] g, input logic [1:0] o,
                       input logic [7:0] qv, input logic e, input string nm);
    @(posedge clk);
    #1;
    bus.req   = rq;
    bus.wen   = we;
    bus.wdata = wd;
    bus.sclr  = sc;
    push_exp(1, g, o, qv, e, nm);
  endtask

  // monitor
  logic [W-1:0] mon_e;
  string        mon_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][30:15] <= cyc_cnt) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      if (mon_e[30:15] != cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked, now cycle %0d", mon_nm, mon_e[30:15], cyc_cnt);
      end else begin
        chk(mon_nm, "gnt", {4'b0, bus.gnt}, {4'b0, mon_e[14:11]});
        if (mon_e[14:11] != 4'b0) chk(mon_nm, "owner", {6'b0, bus.owner}, {6'b0, mon_e[10:9]});
        chk(mon_nm, "q", bus.q, mon_e[8:1]);
        chk(mon_nm, "wen_err", {7'b0, bus.wen_err}, {7'b0, mon_e[0]});
      end
    end
  end

  initial begin
    bus.req = '0; bus.wen = '0; bus.wdata = '0; bus.sclr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp(0, 4'b0000, 2'd0, 8'h00, 1'b0, "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin from reset pointer: 0,1,2,3,0 each for 4 cycles, no gaps
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b1111, 4'b0, 32'h0, 1'b0, 4'(1 << (((k - 1) / 4) % 4)),
            2'(((k - 1) / 4) % 4), 8'h00, 1'b0, "rr");
    end
    cycle(4'b0000, 4'b0, 32'h0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, "rr_drop");

    // single requester and write
    cycle(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 2'd1, 8'h00, 1'b0, "single_grant");
    cycle(4'b0010, 4'b0010, 32'h0000_3C00, 1'b0, 4'b0010, 2'd1, 8'h3C, 1'b0, "single_write");
    cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 2'd0, 8'h3C, 1'b0, "single_release");

    // sole requester across hold expiries
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0100, 4'b0, 32'h0, 1'b0, 4'b0100, 2'd2, 8'h3C, 1'b0, "hold_sole");
    end
    cycle(4'b0000, 4'b0, 32'h0, 1'b0, 4'b0000, 2'd0, 8'h3C, 1'b0, "hold_drop");

    // non-owner write
    cycle(4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0001, 2'd0, 8'h3C, 1'b0, "own0_grant");
    cycle(4'b0001, 4'b0100, 32'h00FF_0000, 1'b0, 4'b0001, 2'd0, 8'h3C, 1'b1, "illegal_write");
    cycle(4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0001, 2'd0, 8'h3C, 1'b0, "err_pulse_end");

    // sclr against write; write on regrant and on release
    cycle(4'b0001, 4'b0001, 32'h0000_0055, 1'b0, 4'b0001, 2'd0, 8'h55, 1'b0, "owner_write");
    cycle(4'b0001, 4'b0001, 32'h0000_00AA, 1'b1, 4'b0001, 2'd0, 8'h00, 1'b0, "sclr_wins");
    cycle(4'b0001, 4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 2'd0, 8'hA5, 1'b0, "write_after_sclr");
    cycle(4'b0000, 4'b0001, 32'h0000_005A, 1'b0, 4'b0000, 2'd0, 8'h5A, 1'b0, "write_on_release");

    // async reset in the middle of a grant
    cycle(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 2'd1, 8'h5A, 1'b0, "pre_reset_grant");
    cycle(4'b0010, 4'b0010, 32'h0000_A500, 1'b0, 4'b0010, 2'd1, 8'hA5, 1'b0, "pre_reset_write");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", "gnt", {4'b0, bus.gnt}, 8'h00);
    chk("async_reset", "q", bus.q, 8'h00);
    chk("async_reset", "wen_err", {7'b0, bus.wen_err}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = '0; bus.wen = '0; bus.wdata = '0;

    // pointer back to 0: req 1010 must pick requester 1
    cycle(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0010, 2'd1, 8'h00, 1'b0, "ptr_reset");
    cycle(4'b0000, 4'b1000, 32'h0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, "nonowner_wen_err");
    cycle(4'b0000, 4'b0001, 32'h0000_0077, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, "idle_write_rejected");
    cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, "idle_quiet");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
